// File: rtl/cordic_atan_sched.sv
// Iterative CORDIC vectoring engine (atan in degrees, Q8.24) shared round-robin between two
// requesters; one micro-rotation per clock, result tagged with the requester id.
module cordic_atan_sched #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [31:0] x_a,
  input  logic [31:0] y_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [31:0] x_b,
  input  logic [31:0] y_b,
  output logic        gnt_b,
  output logic        busy,
  output logic        done,
  output logic        done_id,
  output logic [31:0] result
);

  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic {StIdle, StRun} state_e;

  // arctan(2^-i) in degrees, Q8.32, truncated
  function automatic logic [39:0] atan_lut(input logic [5:0] idx);
    logic [39:0] v;
    case (idx)
      6'd0:  v = 40'h2D00000000;
      6'd1:  v = 40'h1A90A731A6;
      6'd2:  v = 40'h0E0947407D;
      6'd3:  v = 40'h0720011249;
      6'd4:  v = 40'h03938AA64C;
      6'd5:  v = 40'h01CA3794E5;
      6'd6:  v = 40'h00E52A1AB1;
      6'd7:  v = 40'h007296D7A1;
      6'd8:  v = 40'h00394BA51B;
      6'd9:  v = 40'h001CA5D9B7;
      6'd10: v = 40'h000E52EDC0;
      6'd11: v = 40'h00072976FD;
      6'd12: v = 40'h000394BB82;
      6'd13: v = 40'h0001CA5DC1;
      6'd14: v = 40'h0000E52EE0;
      6'd15: v = 40'h0000729770;
      6'd16: v = 40'h0000394BB8;
      6'd17: v = 40'h00001CA5DC;
      6'd18: v = 40'h00000E52EE;
      6'd19: v = 40'h0000072977;
      6'd20: v = 40'h00000394BB;
      6'd21: v = 40'h000001CA5D;
      6'd22: v = 40'h000000E52E;
      6'd23: v = 40'h0000007297;
      6'd24: v = 40'h000000394B;
      6'd25: v = 40'h0000001CA5;
      6'd26: v = 40'h0000000E52;
      6'd27: v = 40'h0000000729;
      6'd28: v = 40'h0000000394;
      6'd29: v = 40'h00000001CA;
      6'd30: v = 40'h00000000E5;
      6'd31: v = 40'h0000000072;
      6'd32: v = 40'h0000000039;
      6'd33: v = 40'h000000001C;
      6'd34: v = 40'h000000000E;
      6'd35: v = 40'h0000000007;
      6'd36: v = 40'h0000000003;
      6'd37: v = 40'h0000000001;
      default: v = 40'h0000000000;
    endcase
    return v;
  endfunction

  // Two guard bits absorb the CORDIC gain; eight fraction bits limit shift truncation error.
  function automatic logic signed [41:0] widen(input logic [31:0] v);
    return {{2{v[31]}}, v, 8'h00};
  endfunction

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic signed [41:0] xr_q, xr_d, yr_q, yr_d;
  logic signed [39:0] zr_q, zr_d;
  logic               last_id_q, last_id_d;
  logic               id_q, id_d;
  logic               gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic               done_q, done_d, done_id_q, done_id_d;
  logic [31:0]        result_q, result_d;

  logic signed [41:0] x_sh, y_sh;
  logic signed [39:0] at_s, z_nxt;
  logic               grant_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    xr_d      = xr_q;
    yr_d      = yr_q;
    zr_d      = zr_q;
    last_id_d = last_id_q;
    id_d      = id_q;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    result_d  = result_q;

    x_sh    = xr_q >>> cnt_q;
    y_sh    = yr_q >>> cnt_q;
    at_s    = $signed(atan_lut(6'(cnt_q)));
    z_nxt   = yr_q[41] ? (zr_q - at_s) : (zr_q + at_s);
    // On a tie B wins only if A was served last
    grant_b = req_b & (~req_a | ~last_id_q);

    unique case (state_q)
      StIdle: begin
        if (req_a | req_b) begin
          state_d   = StRun;
          cnt_d     = '0;
          zr_d      = '0;
          xr_d      = grant_b ? widen(x_b) : widen(x_a);
          yr_d      = grant_b ? widen(y_b) : widen(y_a);
          id_d      = grant_b;
          last_id_d = grant_b;
          gnt_a_d   = ~grant_b;
          gnt_b_d   = grant_b;
        end
      end
      StRun: begin
        if (!yr_q[41]) begin
          xr_d = xr_q + y_sh;
          yr_d = yr_q - x_sh;
        end else begin
          xr_d = xr_q - y_sh;
          yr_d = yr_q + x_sh;
        end
        zr_d  = z_nxt;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(ITER - 1)) begin
          state_d   = StIdle;
          cnt_d     = '0;
          done_d    = 1'b1;
          done_id_d = id_q;
          result_d  = z_nxt[39:8];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      xr_q      <= '0;
      yr_q      <= '0;
      zr_q      <= '0;
      last_id_q <= 1'b1;
      id_q      <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      xr_q      <= xr_d;
      yr_q      <= yr_d;
      zr_q      <= zr_d;
      last_id_q <= last_id_d;
      id_q      <= id_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
    end
  end

  assign gnt_a   = gnt_a_q;
  assign gnt_b   = gnt_b_q;
  assign busy    = (state_q == StRun);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;

endmodule
